ram: RTL and testbench

//  - Single-port, word-organised data memory for the processor data path.
//  - Writes are synchronous on clk. Reads are combinational from the addressed word.
//  - 32-bit data. Byte addresses are converted to word indices: addr_i[1:0] is ignored.
//  - Sits behind the bus/LSU. Full-word writes only.

---
 rtl/ram.sv | 48 ++++
 tb/tb_ram.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/ram.sv
// ram: single-port, word-organised data memory with synchronous writes and combinational reads.
// Optional define RAM_BOUNDS_CHECK_EN: out-of-range addresses read as zero and never write; otherwise addresses wrap modulo DEPTH.
module ram #(
    parameter int DEPTH = 4096,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [31:0]   addr_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] data_o
);

    localparam int AW = $clog2(DEPTH);

    // Zero at power-up via the declaration initialiser; reset deliberately leaves contents intact.
    logic [DW-1:0] mem_q [DEPTH] = '{default: '0};

    logic [AW-1:0] idx;
    logic          in_range;
    logic          wr_en;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{addr_i[31:AW+2], addr_i[1:0]};

    always_comb begin
        idx = addr_i[AW+1:2];
`ifdef RAM_BOUNDS_CHECK_EN
        in_range = (addr_i[31:AW+2] == '0);
`else
        in_range = 1'b1;
`endif
        wr_en  = rst && we_i && in_range;
        data_o = '0;
        if (rst && in_range) begin
            data_o = mem_q[idx];
        end
    end

    // rst is sampled at the edge, so a reset that falls before the edge blocks the write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[idx] <= data_i;
        end
    end

endmodule

// File: tb/tb_ram.sv
// tb_ram: scoreboard bench for ram; a driver queues expected read data from a reference model
// while a monitor compares data_o against the queue on each falling clock edge.
module tb_ram;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    ram #(.DEPTH(DEPTH), .DW(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .we_i   (we_i),
        .addr_i (addr_i),
        .data_i (data_i),
        .data_o (data_o)
    );

    always #10 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model [DEPTH];
    int          checks = 0;
    int          failures = 0;
    bit          stim_done = 1'b0;

    function automatic bit model_in_range(input logic [31:0] a);
`ifdef RAM_BOUNDS_CHECK_EN
        return (a / 4) < DEPTH;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic logic [31:0] model_read(input logic r, input logic [31:0] a);
        if (!r || !model_in_range(a)) return 32'h0;
        return model[model_idx(a)];
    endfunction

    // One clock: commit the write the previous inputs cause at this edge, then drive new inputs.
    task automatic step(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input string name);
        exp_t e;
        @(posedge clk);
        if (rst && we_i && model_in_range(addr_i)) model[model_idx(addr_i)] = data_i;
        #1;
        rst    = r;
        we_i   = w;
        addr_i = a;
        data_i = d;
        e.name = name;
        e.exp  = model_read(r, a);
        sb_q.push_back(e);
    endtask

    // Monitor: the DUT presents read data every cycle; check one queued expectation per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (data_o !== e.exp) begin
                    failures++;
                    $display("[TB] FAIL %s: data_o=%h expected=%h (addr=%h rst=%b we=%b)",
                             e.name, data_o, e.exp, addr_i, rst, we_i);
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] hi;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        rst    = 1'b0;
        we_i   = 1'b0;
        addr_i = 32'h0;
        data_i = 32'h0;

        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'(i * 52), 32'h0, "power_up_reset");
        step(1'b1, 1'b0, 32'h0, 32'h0, "zero_init_addr0");

        step(1'b1, 1'b1, 32'h0, 32'hAAAA_AAAA, "write_same_cycle_old");
        step(1'b1, 1'b0, 32'h0, 32'h0, "write_readback");
        step(1'b1, 1'b1, 32'h0, 32'hAAAA_ACDA, "overwrite_same_cycle_old");
        step(1'b1, 1'b0, 32'h0, 32'h0, "overwrite_readback");

        step(1'b1, 1'b1, 32'h4, 32'h0BAD_CAFE, "prefill_addr4");
        step(1'b0, 1'b1, 32'h4, 32'h1234_5678, "reset_gating_out");
        step(1'b0, 1'b1, 32'h4, 32'h1234_5678, "reset_gating_out");
        step(1'b1, 1'b0, 32'h4, 32'h0, "reset_no_write_no_clear");
        step(1'b1, 1'b0, 32'h0, 32'h0, "reset_kept_addr0");

        step(1'b1, 1'b1, 32'h8, 32'h1111_1111, "addr8_write");
        step(1'b1, 1'b0, 32'h9, 32'h0, "unaligned_9");
        step(1'b1, 1'b0, 32'hA, 32'h0, "unaligned_10");
        step(1'b1, 1'b0, 32'hB, 32'h0, "unaligned_11");
        step(1'b1, 1'b0, 32'hC, 32'h0, "next_word_12");

        step(1'b1, 1'b1, 32'(DEPTH * 4), 32'hDEAD_BEEF, "bounds_write");
        step(1'b1, 1'b0, 32'(DEPTH * 4), 32'h0, "bounds_read_high");
        step(1'b1, 1'b0, 32'h0, 32'h0, "bounds_word0");
        step(1'b1, 1'b0, 32'(DEPTH * 4 - 4), 32'h0, "last_word");

        for (int i = 0; i < 300; i++) begin
            a  = 32'($urandom_range(0, 127));
            hi = ($urandom_range(0, 9) == 0) ? ($urandom() << 14) : 32'h0;
            step(($urandom_range(0, 19) != 0), $urandom_range(0, 1) == 1, a | hi,
                 $urandom(), "random");
        end
        step(1'b1, 1'b0, 32'h0, 32'h0, "final_read");

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        stim_done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
